// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: control-side and MAC-side signals of the operand sequencer
interface mac_operand_sequencer_if #(parameter int VEC_LEN = 4);
  logic start;
  logic [2*VEC_LEN-1:0] vec_a;
  logic [2*VEC_LEN-1:0] vec_b;
  logic busy;
  logic [1:0] mac_a;
  logic [1:0] mac_b;
  logic mac_enable;
  logic mac_clear;
  logic [7:0] mac_out;
  logic [7:0] result;
  logic result_valid;
  logic result_ready;
  logic mismatch;
  modport master (
    output start, vec_a, vec_b, mac_out, result_ready,
    input  busy, mac_a, mac_b, mac_enable, mac_clear, result, result_valid, mismatch
  );
  modport slave (
    input  start, vec_a, vec_b, mac_out, result_ready,
    output busy, mac_a, mac_b, mac_enable, mac_clear, result, result_valid, mismatch
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams latched operand pairs into a MAC and returns the dot product; MAC_SEQ_CHECK_EN adds a shadow-accumulator cross-check
module mac_operand_sequencer #(
  parameter int VEC_LEN = 4,
  parameter int IDX_W = 5
) (
  input logic clk,
  input logic reset,
  mac_operand_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [2*VEC_LEN-1:0] lat_a, lat_b;
  logic [7:0] res;
  logic res_v;
  logic mis;
  logic last;
  assign last = idx == IDX_W'(VEC_LEN - 1);
  assign bus.busy = state != IDLE;
  assign bus.mac_clear = state == CLEAR;
  assign bus.mac_enable = state == FEED;
  assign bus.mac_a = state == FEED ? lat_a[1:0] : 2'd0;
  assign bus.mac_b = state == FEED ? lat_b[1:0] : 2'd0;
  assign bus.result = res;
  assign bus.result_valid = res_v;
  assign bus.mismatch = mis;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.start ? CLEAR : IDLE;
      CLEAR:   state_nxt = FEED;
      FEED:    state_nxt = last ? CAPTURE : FEED;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = bus.result_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // operands are latched on start and shifted down so element[index] always sits in the low bits
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      lat_a <= '0;
      lat_b <= '0;
      res <= '0;
      res_v <= 1'b0;
    end else begin
      idx <= state == FEED ? idx + 1'b1 : '0;
      if (state == IDLE && bus.start) begin
        lat_a <= bus.vec_a;
        lat_b <= bus.vec_b;
      end else if (state == FEED) begin
        lat_a <= lat_a >> 2;
        lat_b <= lat_b >> 2;
      end
      if (state == CAPTURE) begin
        res <= bus.mac_out;
        res_v <= 1'b1;
      end else if (state == DONE && bus.result_ready) res_v <= 1'b0;
    end
`ifdef MAC_SEQ_CHECK_EN
  logic [7:0] shadow;
  // shadow accumulator mirrors the MAC and flags any disagreement at capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow <= '0;
      mis <= 1'b0;
    end else begin
      if (state == CLEAR) shadow <= '0;
      else if (state == FEED) shadow <= shadow + 8'(bus.mac_a) * 8'(bus.mac_b);
      if (state == CAPTURE) mis <= bus.mac_out != shadow;
      else if (state == DONE && bus.result_ready) mis <= 1'b0;
    end
`else
  assign mis = 1'b0;
`endif
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed scoreboard bench for the operand sequencer with behavioural MAC models
module tb_mac_operand_sequencer;
  localparam int VEC_LEN = 4;
`ifdef MAC_SEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic force0 = 1'b0;
  logic [7:0] acc, acc28;
  logic [8:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  mac_operand_sequencer_if #(.VEC_LEN(VEC_LEN)) bus ();
  mac_operand_sequencer_if #(.VEC_LEN(28)) bus28 ();
  mac_operand_sequencer #(.VEC_LEN(VEC_LEN), .IDX_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  mac_operand_sequencer #(.VEC_LEN(28), .IDX_W(5)) dut28 (.clk(clk), .reset(reset), .bus(bus28));
  always #5 clk = ~clk;
  // behavioural MAC for the 4-element instance; force0 corrupts bit 0 of its output
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (bus.mac_clear) acc <= '0;
    else if (bus.mac_enable) acc <= acc + 8'(bus.mac_a) * 8'(bus.mac_b);
  assign bus.mac_out = acc | {7'd0, force0};
  // behavioural MAC for the 28-element instance
  always_ff @(posedge clk or posedge reset)
    if (reset) acc28 <= '0;
    else if (bus28.mac_clear) acc28 <= '0;
    else if (bus28.mac_enable) acc28 <= acc28 + 8'(bus28.mac_a) * 8'(bus28.mac_b);
  assign bus28.mac_out = acc28;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, input int hold);
    int cyc, clr, en;
    logic [8:0] got;
    logic [7:0] r0;
    bus.vec_a = a;
    bus.vec_b = b;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    cyc = 0;
    clr = 0;
    en = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.vec_a = ~a;
      cyc++;
      clr += int'(bus.mac_clear);
      en += int'(bus.mac_enable);
    end while (!bus.result_valid && cyc < 50);
    check("latency", cyc - 1, VEC_LEN + 2);
    check("clear_pulses", clr, 1);
    check("enable_cycles", en, VEC_LEN);
    got = exp_q.pop_front();
    check("result", bus.result, got[7:0]);
    check("mismatch", bus.mismatch, got[8]);
    r0 = bus.result;
    for (int i = 0; i < hold; i++) begin
      bus.start = 1'b1;
      @(negedge clk);
      check("hold_valid", bus.result_valid, 1);
      check("hold_result", bus.result, r0);
      check("hold_busy", bus.busy, 1);
    end
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("hs_valid", bus.result_valid, 0);
    check("hs_busy", bus.busy, 0);
    check("hs_result_kept", bus.result, r0);
    check("hs_mismatch", bus.mismatch, 0);
    if (hold > 0) begin
      @(negedge clk);
      check("no_queued_start", bus.busy, 0);
    end
  endtask

  initial begin
    int cyc;
    logic [8:0] got;
    bus.start = 1'b0;
    bus.vec_a = '0;
    bus.vec_b = '0;
    bus.result_ready = 1'b0;
    bus28.start = 1'b0;
    bus28.vec_a = '0;
    bus28.vec_b = '0;
    bus28.result_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_outs", {bus.mac_a, bus.mac_b, bus.mac_enable, bus.mac_clear}, 0);
    check("rst_result", bus.result, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_mismatch", bus.mismatch, 0);
    reset = 1'b0;
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(negedge clk);
    check("ready_outside_done", bus.busy, 0);
    bus.result_ready = 1'b0;
    run(8'b11_10_01_00, 8'hFF, {1'b0, 8'd18}, 0);
    run(8'hFF, 8'hFF, {1'b0, 8'd36}, 5);
    run(8'h55, 8'h55, {1'b0, 8'd4}, 0);
    run(8'hAA, 8'h55, {1'b0, 8'd8}, 0);
    // abort in the 2nd FEED cycle
    bus.vec_a = 8'hFF;
    bus.vec_b = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_feed", bus.mac_enable, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_mac", {bus.mac_a, bus.mac_b, bus.mac_enable, bus.mac_clear}, 0);
    check("abort_result", bus.result, 0);
    check("abort_valid", bus.result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_idle", bus.busy, 0);
    check("post_abort_valid", bus.result_valid, 0);
    run(8'b11_10_01_00, 8'hFF, {1'b0, 8'd18}, 0);
    force0 = 1'b1;
    run(8'b11_10_01_00, 8'hFF, {CHK, 8'd19}, 0);
    force0 = 1'b0;
    run(8'b11_10_01_00, 8'hFF, {1'b0, 8'd18}, 0);
    // 28-element build, all operands 3
    bus28.vec_a = '1;
    bus28.vec_b = '1;
    bus28.start = 1'b1;
    exp_q.push_back({1'b0, 8'd252});
    cyc = 0;
    do begin
      @(negedge clk);
      bus28.start = 1'b0;
      cyc++;
    end while (!bus28.result_valid && cyc < 100);
    check("latency28", cyc - 1, 30);
    got = exp_q.pop_front();
    check("result28", bus28.result, got[7:0]);
    check("mismatch28", bus28.mismatch, got[8]);
    bus28.result_ready = 1'b1;
    @(negedge clk);
    bus28.result_ready = 1'b0;
    check("idle28", bus28.busy, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
